// File: rtl/interfaz_tx.sv
// -----------------------------------------------------------------------------
// interfaz_tx
//   Return path from the ALU to the UART transmitter. Latches one ALU result,
//   splits it into NB_DBIT-wide bytes (LSB byte first) and hands them one at a
//   time to the UART TX core. Each byte gets a one-cycle start pulse, and the
//   next byte waits for the TX core's done pulse.
//
//   Optional feature (macro INTERFAZ_TX_CHECKSUM_EN):
//     when defined, one extra byte is sent after the data bytes. It holds the
//     XOR of all N_BYTES data bytes, so a frame is N_BYTES+1 transfers.
//
//   Parameters:
//     NB_DBIT  UART data width in bits
//     N_BYTES  bytes per ALU result (>= 1)
//
//   Ports:
//     i_clk         system clock, rising edge
//     i_rst         asynchronous active-low reset
//     i_alu_result  ALU result to transmit (NB_DBIT*N_BYTES bits)
//     i_alu_valid   one-cycle pulse, result valid (only honoured in IDLE)
//     i_tx_done     one-cycle pulse from TX core, byte shifted out
//     o_data        byte presented to the TX core (held after the frame)
//     o_tx_start    one-cycle pulse, TX core loads o_data
//     o_busy        high from result latch until the frame completes
//     o_done        one-cycle pulse, whole result transmitted
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | waiting for i_alu_valid
//   ST_START | o_tx_start is high for the current byte (one cycle)
//   ST_WAIT  | byte handed over, waiting for i_tx_done
//   ST_DONE  | o_done is high (one cycle), then back to idle
// -----------------------------------------------------------------------------
module interfaz_tx #(
  parameter int NB_DBIT = 8,
  parameter int N_BYTES = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NB_DBIT*N_BYTES-1:0] i_alu_result,
  input  logic                       i_alu_valid,
  input  logic                       i_tx_done,
  output logic [NB_DBIT-1:0]         o_data,
  output logic                       o_tx_start,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NB_RES = NB_DBIT * N_BYTES;
  localparam int CNT_W  = $clog2(N_BYTES + 1);

`ifdef INTERFAZ_TX_CHECKSUM_EN
  // The checksum occupies transfer index N_BYTES.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES);
`else
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NB_RES-1:0]  result_q, result_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   nxt_idx;
  logic [NB_DBIT-1:0] next_byte;
  logic [NB_DBIT-1:0] data_d;
  logic               tx_start_d;
  logic               busy_d;
  logic               done_d;

  assign nxt_idx = byte_cnt_q + CNT_W'(1);

`ifdef INTERFAZ_TX_CHECKSUM_EN
  logic [NB_DBIT-1:0] checksum;

  always_comb begin
    checksum = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      checksum = checksum ^ result_q[b*NB_DBIT +: NB_DBIT];
    end
  end
`endif

  // Byte that follows the current one; constant-index selects keep the mux
  // free of out-of-range reads when nxt_idx points past the data bytes.
  always_comb begin
    next_byte = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      if (nxt_idx == CNT_W'(b)) begin
        next_byte = result_q[b*NB_DBIT +: NB_DBIT];
      end
    end
`ifdef INTERFAZ_TX_CHECKSUM_EN
    if (nxt_idx == CNT_W'(N_BYTES)) begin
      next_byte = checksum;
    end
`endif
  end

  // Outputs are computed one state ahead so they are registered together
  // with the state they belong to.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = o_data;
    tx_start_d = 1'b0;
    busy_d     = o_busy;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_alu_valid) begin
          result_d   = i_alu_result;
          byte_cnt_d = '0;
          data_d     = i_alu_result[NB_DBIT-1:0];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        busy_d  = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        busy_d = 1'b1;
        if (i_tx_done) begin
          if (byte_cnt_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            byte_cnt_d = nxt_idx;
            data_d     = next_byte;
            tx_start_d = 1'b1;
            state_d    = ST_START;
          end
        end
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      byte_cnt_q <= '0;
      o_data     <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      byte_cnt_q <= byte_cnt_d;
      o_data     <= data_d;
      o_tx_start <= tx_start_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
    end
  end

endmodule

// File: tb/tb_interfaz_tx.sv
module tb_interfaz_tx;

  logic        clk;
  logic        rst_n;
  logic        sel;        // 0: two-byte instance, 1: one-byte instance
  logic [15:0] res_in;
  logic        valid;
  logic        tx_done;

  logic        valid2, valid1, tx_done2, tx_done1;
  logic [7:0]  data2, data1;
  logic        start2, start1, busy2, busy1, done2, done1;

  logic [7:0]  data_o;
  logic        start_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  assign valid2   = valid & ~sel;
  assign valid1   = valid & sel;
  assign tx_done2 = tx_done & ~sel;
  assign tx_done1 = tx_done & sel;

  assign data_o  = sel ? data1  : data2;
  assign start_o = sel ? start1 : start2;
  assign busy_o  = sel ? busy1  : busy2;
  assign done_o  = sel ? done1  : done2;

  interfaz_tx #(.NB_DBIT(8), .N_BYTES(2)) u_dut2 (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_alu_result (res_in),
    .i_alu_valid  (valid2),
    .i_tx_done    (tx_done2),
    .o_data       (data2),
    .o_tx_start   (start2),
    .o_busy       (busy2),
    .o_done       (done2)
  );

  interfaz_tx #(.NB_DBIT(8), .N_BYTES(1)) u_dut1 (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_alu_result (res_in[7:0]),
    .i_alu_valid  (valid1),
    .i_tx_done    (tx_done1),
    .o_data       (data1),
    .o_tx_start   (start1),
    .o_busy       (busy1),
    .o_done       (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: LSB byte first, optional XOR byte appended. The bench
  // answers each start with i_tx_done after 'gap' waiting cycles.
  task automatic run_frame(input bit use1, input logic [15:0] val, input int gap, input bit poke);
    logic [7:0] exp_q[$];
    logic [7:0] x;
    int nb;
    nb = use1 ? 1 : 2;
    x = 8'h00;
    sel = use1;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(8'((val >> (8 * i)) & 16'h00FF));
      x = x ^ exp_q[i];
    end
`ifdef INTERFAZ_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    chk("idle_busy", 16'(busy_o), 16'd0);
    res_in = val;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    res_in = 16'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("start_hi", 16'(start_o), 16'd1);
      chk("start_data", 16'(data_o), 16'(exp_q[i]));
      chk("busy_frame", 16'(busy_o), 16'd1);
      chk("done_early", 16'(done_o), 16'd0);
      for (int c = 0; c < gap; c++) begin
        @(negedge clk);
        valid = 1'b0;
        chk("start_lo", 16'(start_o), 16'd0);
        chk("data_hold", 16'(data_o), 16'(exp_q[i]));
        chk("done_wait", 16'(done_o), 16'd0);
        if (poke && i == 0 && c == 0) begin
          res_in = 16'hFFFF;
          valid = 1'b1;
        end
      end
      valid = 1'b0;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    chk("done_hi", 16'(done_o), 16'd1);
    chk("busy_done", 16'(busy_o), 16'd1);
    chk("start_in_done", 16'(start_o), 16'd0);
    if (poke) begin
      res_in = 16'hFFFF;
      valid = 1'b1;
    end
    @(negedge clk);
    valid = 1'b0;
    chk("done_lo", 16'(done_o), 16'd0);
    chk("busy_fall", 16'(busy_o), 16'd0);
    chk("data_keep", 16'(data_o), 16'(exp_q[exp_q.size() - 1]));
    @(negedge clk);
    chk("no_restart", 16'(start_o), 16'd0);
    chk("idle_after", 16'(busy_o), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sel = 1'b0;
    res_in = 16'h0000;
    valid = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data2", 16'(data2), 16'd0);
    chk("rst_start2", 16'(start2), 16'd0);
    chk("rst_busy2", 16'(busy2), 16'd0);
    chk("rst_done2", 16'(done2), 16'd0);
    chk("rst_data1", 16'(data1), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two-byte frame with an ignored valid during WAIT and in DONE
    run_frame(1'b0, 16'hA53C, 5, 1'b1);
    run_frame(1'b0, 16'h1234, 5, 1'b0);

    // One-byte frame
    run_frame(1'b1, 16'h0008, 5, 1'b0);

    // Spurious i_tx_done in IDLE
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("spur_start", 16'(start_o), 16'd0);
      chk("spur_busy", 16'(busy_o), 16'd0);
      @(negedge clk);
      chk("spur_start2", 16'(start_o), 16'd0);
    end

    // i_tx_done held three cycles: one advance per WAIT entry
    sel = 1'b0;
    res_in = 16'h1234;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("hold_start0", 16'(start_o), 16'd1);
    chk("hold_data0", 16'(data_o), 16'h0034);
    repeat (3) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    chk("hold_start1", 16'(start_o), 16'd1);
    chk("hold_data1", 16'(data_o), 16'h0012);
    @(negedge clk);
    chk("hold_start_ign", 16'(start_o), 16'd0);
    chk("hold_done_ign", 16'(done_o), 16'd0);
    @(negedge clk);
    tx_done = 1'b0;
`ifdef INTERFAZ_TX_CHECKSUM_EN
    chk("hold_start_cs", 16'(start_o), 16'd1);
    chk("hold_data_cs", 16'(data_o), 16'h0026);
    repeat (2) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
`endif
    chk("hold_done", 16'(done_o), 16'd1);
    @(negedge clk);
    chk("hold_idle", 16'(busy_o), 16'd0);
    chk("hold_done_lo", 16'(done_o), 16'd0);

    // Asynchronous reset in the middle of WAIT for byte 0
    sel = 1'b0;
    res_in = 16'hBEEF;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("arst_start", 16'(start_o), 16'd1);
    repeat (2) @(negedge clk);
    chk("arst_busy_pre", 16'(busy2), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", 16'(data2), 16'd0);
    chk("arst_start0", 16'(start2), 16'd0);
    chk("arst_busy", 16'(busy2), 16'd0);
    chk("arst_done", 16'(done2), 16'd0);
    repeat (2) @(negedge clk);
    chk("arst_no_done", 16'(done2), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_no_resume", 16'(start2), 16'd0);
    run_frame(1'b0, 16'h00FF, 5, 1'b0);

    // Randomized frames
    for (int k = 0; k < 8; k++) begin
      run_frame(1'($urandom_range(0, 1)), 16'($urandom), $urandom_range(1, 6), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
